// File: rtl/adder_tree_pipe_pkg.sv
// Shared sizing helpers for the pipelined adder tree.
// All functions are constant functions, usable in parameter and port widths.
package adder_tree_pipe_pkg;

  // Number of pairwise reduction levels: ceil(log2(n)), n >= 2.
  function automatic int num_stages(input int n);
    int s;
    s = 0;
    for (int p = 1; p < n; p = p * 2) begin
      s++;
    end
    return s;
  endfunction

  // Full-precision sum width: one growth bit per reduction level.
  function automatic int owidth(input int dw, input int n);
    return dw + num_stages(n);
  endfunction

  // Operand count rounded up to a power of two (extra lanes are zero).
  function automatic int padded_count(input int n);
    return 1 << num_stages(n);
  endfunction

  // Element offset of reduction level l inside the flattened level chain.
  // Level 0 holds npad elements, level 1 holds npad/2, and so on.
  function automatic int level_offset(input int npad, input int l);
    return 2 * npad - 2 * (npad >> l);
  endfunction

endpackage

// File: rtl/adder_tree_pipe_stage.sv
// One registered reduction level of the adder tree.
// Pairs element i with element i+NUM_IN/2; valid and last travel alongside.
// Everything holds when en is low. Operands arrive already extended to WIDTH,
// so the add never needs to grow.
module adder_tree_pipe_stage #(
  parameter int NUM_IN = 2,
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [NUM_IN*WIDTH-1:0]       in_dat,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [(NUM_IN/2)*WIDTH-1:0]   out_dat
);

  localparam int NUM_OUT = NUM_IN / 2;

  logic [NUM_OUT*WIDTH-1:0] dat_q, dat_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;

  // Next-state: pairwise sums plus sideband, frozen while en is low.
  always_comb begin
    dat_d   = dat_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (en) begin
      valid_d = in_valid;
      last_d  = in_last;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (SIGNED != 0) begin
          dat_d[i*WIDTH +: WIDTH] = $signed(in_dat[i*WIDTH +: WIDTH])
                                  + $signed(in_dat[(i+NUM_OUT)*WIDTH +: WIDTH]);
        end else begin
          dat_d[i*WIDTH +: WIDTH] = in_dat[i*WIDTH +: WIDTH]
                                  + in_dat[(i+NUM_OUT)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Stage registers, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      dat_q   <= dat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_dat   = dat_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined adder tree: reduces NUM_INPUTS operands to one full-precision sum.
// Optional frame accumulator enabled by defining ADDER_TREE_PIPE_ACC_EN.
//
// Handshake: a beat transfers on a port when its valid and ready are both high
// at a rising clk edge. The whole pipeline advances together under
// en = !(o_valid && !o_ready), and i_ready is en, so a stalled output freezes
// every stage and upstream sees back-pressure in the same cycle.
module adder_tree_pipe
  import adder_tree_pipe_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH     = 8,
  parameter int SIGNED     = 0,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_valid,
  output logic                                       i_ready,
  input  logic [NUM_INPUTS*DWIDTH-1:0]               i_dat_vector,
  input  logic                                       i_last,
  output logic                                       o_valid,
  input  logic                                       o_ready,
  output logic [DWIDTH+num_stages(NUM_INPUTS)-1:0]   o_sum,
  output logic                                       o_acc_valid,
  output logic [ACC_WIDTH-1:0]                       o_acc
);

  localparam int NUM_STAGES = num_stages(NUM_INPUTS);
  localparam int OWIDTH     = owidth(DWIDTH, NUM_INPUTS);
  localparam int NPAD       = padded_count(NUM_INPUTS);

  // All reduction levels laid end to end: level 0 is the extended input,
  // level NUM_STAGES is the single final sum.
  logic [(2*NPAD-1)*OWIDTH-1:0] chain;
  logic [NUM_STAGES:0]          vld_chain;
  logic [NUM_STAGES:0]          lst_chain;
  logic [NPAD*OWIDTH-1:0]       ext_vec;
  logic                         en;

  assign en      = !(o_valid && !o_ready);
  assign i_ready = en;

  // Extend each operand to full width; padding lanes stay zero.
  always_comb begin
    ext_vec = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (SIGNED != 0) begin
        ext_vec[k*OWIDTH +: OWIDTH] = {{(OWIDTH-DWIDTH){i_dat_vector[k*DWIDTH+DWIDTH-1]}},
                                       i_dat_vector[k*DWIDTH +: DWIDTH]};
      end else begin
        ext_vec[k*OWIDTH +: OWIDTH] = {{(OWIDTH-DWIDTH){1'b0}},
                                       i_dat_vector[k*DWIDTH +: DWIDTH]};
      end
    end
  end

  assign chain[0 +: NPAD*OWIDTH] = ext_vec;
  assign vld_chain[0]            = i_valid;
  assign lst_chain[0]            = i_last;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int NIN = NPAD >> s;
    adder_tree_pipe_stage #(
      .NUM_IN (NIN),
      .WIDTH  (OWIDTH),
      .SIGNED (SIGNED)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (vld_chain[s]),
      .in_last   (lst_chain[s]),
      .in_dat    (chain[level_offset(NPAD, s)*OWIDTH +: NIN*OWIDTH]),
      .out_valid (vld_chain[s+1]),
      .out_last  (lst_chain[s+1]),
      .out_dat   (chain[level_offset(NPAD, s+1)*OWIDTH +: (NIN/2)*OWIDTH])
    );
  end

  assign o_valid = vld_chain[NUM_STAGES];
  assign o_sum   = chain[(2*NPAD-2)*OWIDTH +: OWIDTH];

`ifdef ADDER_TREE_PIPE_ACC_EN
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [ACC_WIDTH-1:0]     acc_out_q, acc_out_d;
  logic                     acc_vld_q, acc_vld_d;
  logic [ACC_WIDTH-1:0]     sum_ext;
  logic signed [OWIDTH-1:0] sum_signed;
  logic                     out_hs;

  assign sum_signed = o_sum;
  assign out_hs     = o_valid && o_ready;

  // Widen the tree sum to accumulator width per operand signedness.
  always_comb begin
    if (SIGNED != 0) begin
      sum_ext = ACC_WIDTH'(sum_signed);
    end else begin
      sum_ext = ACC_WIDTH'(o_sum);
    end
  end

  // Accumulate on each output beat; on a last beat publish the total and restart.
  always_comb begin
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    acc_vld_d = 1'b0;
    if (out_hs) begin
      if (lst_chain[NUM_STAGES]) begin
        acc_out_d = acc_q + sum_ext;
        acc_vld_d = 1'b1;
        acc_d     = '0;
      end else begin
        acc_d     = acc_q + sum_ext;
      end
    end
  end

  // Accumulator registers, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      acc_out_q <= '0;
      acc_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      acc_vld_q <= acc_vld_d;
    end
  end

  assign o_acc       = acc_out_q;
  assign o_acc_valid = acc_vld_q;
`else
  // Frame marker has no consumer without the accumulator.
  logic unused_last;
  assign unused_last = lst_chain[NUM_STAGES];

  assign o_acc_valid = 1'b0;
  assign o_acc       = '0;
`endif

endmodule
